// File: rtl/ppg_peak_detector.sv
// PPG pulse-peak detector: hysteresis peak finder, refractory window, inter-beat interval, timeout.
// Define PEAK_AVG_EN to report the mean of the last four intervals instead of the raw interval.
module ppg_peak_detector #(
    parameter int DATA_W  = 20,
    parameter int CNT_W   = 16,
    parameter int HYST    = 256,
    parameter int MIN_IBI = 50,
    parameter int MAX_IBI = 2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_in,
    output logic              beat_pulse,
    output logic              ibi_valid,
    output logic [CNT_W-1:0]  ibi,
    output logic [DATA_W-1:0] peak_value,
    output logic              timeout
);

    typedef enum logic {
        SEEK_MIN = 1'b0,
        RISING   = 1'b1
    } state_t;

    localparam logic [DATA_W:0]  HYST_X = (DATA_W+1)'(HYST);
    localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_IBI);
    localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_IBI);

    state_t              r_state;
    state_t              w_state_next;
    logic [DATA_W-1:0]   r_min;
    logic [DATA_W-1:0]   w_min_next;
    logic [DATA_W-1:0]   r_max;
    logic [DATA_W-1:0]   w_max_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_have_ref;
    logic                r_to_done;
    logic                r_beat;
    logic                r_ibi_valid;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_ibi;
    logic [DATA_W-1:0]   r_peak;

    logic                w_arm;
    logic                w_fall;
    logic [CNT_W-1:0]    w_cnt_next;
    logic                w_peak;
    logic                w_accept;
    logic                w_interval_ok;
    logic                w_timeout;

    // One extra bit keeps min+HYST and s+HYST from wrapping.
    assign w_arm  = {1'b0, sample_in} >= ({1'b0, r_min} + HYST_X);
    assign w_fall = {1'b0, r_max} >= ({1'b0, sample_in} + HYST_X);

    assign w_cnt_next    = (r_cnt >= MAX_C) ? MAX_C : r_cnt + 1'b1;
    assign w_peak        = sample_valid && (r_state == RISING) && w_fall;
    assign w_accept      = w_peak && !(r_have_ref && (w_cnt_next < MIN_C));
    assign w_interval_ok = r_have_ref && (w_cnt_next < MAX_C);
    assign w_timeout     = sample_valid && !w_accept && (w_cnt_next == MAX_C) && !r_to_done;

    // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
    always_comb begin
        w_state_next = r_state;
        w_min_next   = r_min;
        w_max_next   = r_max;
        if (sample_valid) begin
            case (r_state)
                SEEK_MIN: begin
                    if (sample_in < r_min) w_min_next = sample_in;
                    if (w_arm) begin
                        w_state_next = RISING;
                        w_max_next   = sample_in;
                    end
                end
                RISING: begin
                    if (sample_in > r_max) w_max_next = sample_in;
                    if (w_fall) begin
                        w_state_next = SEEK_MIN;
                        w_min_next   = sample_in;
                    end
                end
                default: w_state_next = SEEK_MIN;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= SEEK_MIN;
            r_min   <= '1;
            r_max   <= '0;
        end else begin
            r_state <= w_state_next;
            r_min   <= w_min_next;
            r_max   <= w_max_next;
        end
    end

`ifdef PEAK_AVG_EN
    logic [CNT_W-1:0] r_hist [3];
    logic [1:0]       r_hist_cnt;
    logic [CNT_W+1:0] w_sum;

    // Window is the new interval plus the three most recent stored ones.
    assign w_sum = (CNT_W+2)'(w_cnt_next) + (CNT_W+2)'(r_hist[0])
                 + (CNT_W+2)'(r_hist[1]) + (CNT_W+2)'(r_hist[2]);

    // NOTE: the history is reset explicitly; stale entries would otherwise leak into the first mean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist[0]  <= '0;
            r_hist[1]  <= '0;
            r_hist[2]  <= '0;
            r_hist_cnt <= '0;
        end else if (w_timeout) begin
            r_hist[0]  <= '0;
            r_hist[1]  <= '0;
            r_hist[2]  <= '0;
            r_hist_cnt <= '0;
        end else if (w_accept && w_interval_ok) begin
            r_hist[0] <= w_cnt_next;
            r_hist[1] <= r_hist[0];
            r_hist[2] <= r_hist[1];
            if (r_hist_cnt != 2'd3) r_hist_cnt <= r_hist_cnt + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_have_ref  <= 1'b0;
            r_to_done   <= 1'b0;
            r_beat      <= 1'b0;
            r_ibi_valid <= 1'b0;
            r_timeout   <= 1'b0;
            r_ibi       <= '0;
            r_peak      <= '0;
        end else begin
            r_beat      <= 1'b0;
            r_ibi_valid <= 1'b0;
            r_timeout   <= 1'b0;
            if (sample_valid) begin
                r_cnt <= w_accept ? '0 : w_cnt_next;
                if (w_accept) begin
                    r_beat     <= 1'b1;
                    r_peak     <= r_max;
                    r_have_ref <= 1'b1;
                    r_to_done  <= 1'b0;
                    if (w_interval_ok) begin
`ifdef PEAK_AVG_EN
                        if (r_hist_cnt == 2'd3) begin
                            r_ibi       <= w_sum[CNT_W+1:2];
                            r_ibi_valid <= 1'b1;
                        end
`else
                        r_ibi       <= w_cnt_next;
                        r_ibi_valid <= 1'b1;
`endif
                    end
                end
                if (w_timeout) begin
                    r_timeout  <= 1'b1;
                    r_have_ref <= 1'b0;
                    r_to_done  <= 1'b1;
                end
            end
        end
    end

    assign beat_pulse = r_beat;
    assign ibi_valid  = r_ibi_valid;
    assign ibi        = r_ibi;
    assign peak_value = r_peak;
    assign timeout    = r_timeout;

endmodule
